// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-and-add multiplier, one multiplier bit per clock, START/BUSY/DONE handshake.
// Define SHIFT_ADD_MULTIPLIER_SIGNED_EN for two's complement operands and product.
module shift_add_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               BUSY,
   output logic               DONE,
   output logic [2*WIDTH-1:0] P
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t state;
   logic [WIDTH-1:0] mcand, mplr, acc_hi, a_mag, b_mag;
   logic [CW-1:0] cnt;
   logic [WIDTH:0] sum;
   logic [2*WIDTH-1:0] prod, res;
   logic take;
   assign take = START && state != RUN;
   assign sum  = {1'b0, acc_hi} + (mplr[0] ? {1'b0, mcand} : '0);
   assign prod = {sum, mplr[WIDTH-1:1]};
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
   logic neg;
   always_ff @(posedge CLK)
      if (RST) neg <= 1'b0;
      else if (take) neg <= A[WIDTH-1] ^ B[WIDTH-1];
   assign a_mag = A[WIDTH-1] ? -A : A;
   assign b_mag = B[WIDTH-1] ? -B : B;
   assign res   = neg ? -prod : prod;
`else
   assign a_mag = A;
   assign b_mag = B;
   assign res   = prod;
`endif
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         mcand  <= '0;
         mplr   <= '0;
         acc_hi <= '0;
         cnt    <= '0;
         P      <= '0;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
      end else begin
         DONE <= 1'b0;
         if (take) begin
            state  <= RUN;
            mcand  <= a_mag;
            mplr   <= b_mag;
            acc_hi <= '0;
            cnt    <= CW'(WIDTH - 1);
            BUSY   <= 1'b1;
         end else if (state == RUN) begin
            {acc_hi, mplr} <= prod;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
               state <= FIN;
               P     <= res;
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
            end
         end else begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed-vector bench for shift_add_multiplier at WIDTH=4.
module tb_shift_add_multiplier;
   logic       CLK, RST, START, BUSY, DONE;
   logic [3:0] A, B;
   logic [7:0] P, last_p;
   int checks = 0, errors = 0;
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
   localparam logic [7:0] E13X11 = 8'h0F, E15X15 = 8'h01;
`else
   localparam logic [7:0] E13X11 = 8'h8F, E15X15 = 8'hE1;
`endif
   shift_add_multiplier #(.WIDTH(4)) dut (
      .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
      .BUSY(BUSY), .DONE(DONE), .P(P)
   );
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
   task automatic step();
      @(posedge CLK);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic run(input logic [3:0] a_in, input logic [3:0] b_in, input logic [7:0] exp, input bit scr);
      START = 1'b1;
      A = a_in;
      B = b_in;
      step();
      START = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("busy_run", BUSY, 1);
         check("done_run", DONE, 0);
         check("p_hold", P, last_p);
         if (scr) begin
            A = 4'($urandom);
            B = 4'($urandom);
         end
         step();
      end
      check("done", DONE, 1);
      check("busy_fin", BUSY, 0);
      check("p", P, exp);
      last_p = exp;
      step();
      check("done_drop", DONE, 0);
      check("p_keep", P, exp);
   endtask
   initial begin
      RST = 1'b1; START = 1'b0; A = '0; B = '0; last_p = '0;
      step();
      step();
      check("rst_p", P, 0);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      RST = 1'b0;
      step();
      run(4'd13, 4'd11, E13X11, 1'b0);
      run(4'd15, 4'd15, E15X15, 1'b0);
      run(4'd0, 4'd9, 8'h00, 1'b0);
      run(4'd9, 4'd0, 8'h00, 1'b0);
      START = 1'b1; A = 4'd3; B = 4'd5;
      step();
      for (int i = 0; i < 3; i++) begin
         check("b2b_busy1", BUSY, 1);
         A = 4'd2; B = 4'd2;
         step();
      end
      check("b2b_busy1", BUSY, 1);
      A = 4'd7; B = 4'd7;
      step();
      check("b2b_done1", DONE, 1);
      check("b2b_busy_fin1", BUSY, 0);
      check("b2b_p1", P, 15);
      step();
      START = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("b2b_busy2", BUSY, 1);
         check("b2b_nodone", DONE, 0);
         START = (i == 1);
         A = 4'd2; B = 4'd2;
         step();
      end
      START = 1'b0;
      check("b2b_done2", DONE, 1);
      check("b2b_p2", P, 49);
      for (int i = 0; i < 6; i++) begin
         step();
         check("b2b_extra_done", DONE, 0);
         check("b2b_idle", BUSY, 0);
      end
      check("b2b_p_keep", P, 49);
      START = 1'b1; A = 4'd12; B = 4'd12;
      step();
      START = 1'b0;
      step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      check("mid_rst_p", P, 0);
      check("mid_rst_busy", BUSY, 0);
      check("mid_rst_done", DONE, 0);
      last_p = '0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("post_rst_done", DONE, 0);
      end
      run(4'd2, 4'd3, 8'h06, 1'b0);
      run(4'd5, 4'd6, 8'h1E, 1'b1);
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
      run(4'h8, 4'h8, 8'h40, 1'b0);
      run(4'hD, 4'h5, 8'hF1, 1'b0);
      run(4'h7, 4'hF, 8'hF9, 1'b0);
      run(4'h8, 4'h7, 8'hC8, 1'b0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential shift-and-add multiplier for the calculator's arithmetic unit. It is the multiply counterpart of the shift-subtract divider. It accepts two WIDTH-bit operands on a START pulse and retires one multiplier bit per clock. It presents a 2*WIDTH-bit product with a one-cycle DONE pulse. It sits beside the divider behind the operation-select mux and uses the same START/BUSY/DONE handshake.

## Interface
- WIDTH, default 4: operand width in bits; minimum 2.
- CLK  in  1: clock; all state updates on rising edge.
- RST  in  1: synchronous, active-high reset.
- START  in  1: request; sampled only when BUSY=0.
- A  in  WIDTH: multiplicand.
- B  in  WIDTH: multiplier.
- BUSY  out  1: high while an operation is in progress.
- DONE  out  1: one-cycle pulse; P is valid from this cycle onward.
- P  out  2*WIDTH: product; holds until the next completion.

## Operation
- FSM states:
  - IDLE: no operation.
  - RUN: iterating.
  - FIN: one cycle, completing.
- IDLE, START=1 -> RUN:
  - mcand<=A, mplr<=B, acc_hi<=0, cnt<=WIDTH-1.
  - A and B are sampled at this edge only; later changes on A and B are ignored.
- RUN, each cycle:
  - sum = {1'b0,acc_hi} + (mplr[0] ? {1'b0,mcand} : 0), WIDTH+1 bits with carry kept.
  - {acc_hi,mplr} <= {sum, mplr[WIDTH-1:1]}, a right shift of the combined register that takes the carry in.
  - cnt decrements each cycle; when cnt==0 the next state is FIN.
- RUN lasts exactly WIDTH cycles, independent of operand values; there is no early termination on zero operands.
- FIN -> IDLE:
  - On the FIN entry edge, P <= {acc_hi,mplr}.
  - DONE=1 and BUSY=0 during the FIN cycle.
- START during FIN is accepted: operands are captured and the next state is RUN, not IDLE. Back-to-back operations have no dead cycle.
- START while BUSY=1 is ignored. It is neither queued nor aborting.
- Arithmetic rules:
  - The product never overflows 2*WIDTH bits.
  - The internal carry is WIDTH+1 bits wide so that 2^WIDTH-1 squared is exact.
- Reset, including mid-operation:
  - State returns to IDLE; the operation in progress is discarded.
  - P=0, BUSY=0, DONE=0, and all internal registers are cleared.

## Timing
- START sampled high at edge 0 while BUSY=0.
- Edge 0: BUSY rises.
- Edges 1..WIDTH: RUN iterations.
- Edge WIDTH: P is updated and DONE is asserted; BUSY falls at the same edge.
- Edge WIDTH+1: DONE falls. This is also the earliest capture edge for a new START, sampled during the FIN cycle.
- Latency from START edge to the first cycle with DONE=1 is WIDTH+1 cycles (cycle count includes FIN); for WIDTH=4, DONE is high 5 cycles after the START edge.
- Throughput: one product per WIDTH+1 cycles.
- P changes only on FIN-entry edges and on reset; it is otherwise stable.
- BUSY and DONE are never high in the same cycle.

## Configuration
- Macro: SHIFT_ADD_MULTIPLIER_SIGNED_EN.
- Defined, signed (two's complement) operands:
  - At capture, mcand<=|A|, mplr<=|B|, and neg<=A[MSB]^B[MSB].
  - At FIN entry, P <= neg ? -{acc_hi,mplr} : {acc_hi,mplr}.
  - A magnitude of -2^(WIDTH-1) is represented as unsigned 2^(WIDTH-1) and fits in WIDTH bits.
  - The largest positive product, (-2^(WIDTH-1))^2, fits in 2*WIDTH signed bits.
- Undefined: operands and P are unsigned; no sign logic is present.
- Latency is identical in both builds.

## Test plan
- Basic product, WIDTH=4, unsigned: START with A=13, B=11 -> BUSY is high for 4 cycles, then P=143 (0x8F) with DONE=1 for exactly 1 cycle, 5 cycles after the START edge.
- Extremes: 15*15 -> P=0xE1, which checks the carry path. 0*9 -> P=0x00 and 9*0 -> P=0x00, each with unchanged latency.
- Back-to-back and ignored START:
  - START held high continuously with A=3, B=5, then A=7, B=7 presented in the FIN cycle -> the first DONE gives P=15, and the second DONE follows 5 cycles later with P=49.
  - A START pulse during RUN with A=2, B=2 is ignored; the products are still 15 and 49, and no extra DONE appears.
- Reset mid-operation: RST=1 in the second RUN cycle of 12*12 -> next cycle P=0, BUSY=0, DONE=0. A subsequent START with A=2, B=3 -> P=6 with normal latency.
- Signed build (SIGNED_EN defined):
  - -8*-8 -> P=0x40.
  - -3*5 -> P=0xF1.
  - 7*-1 -> P=0xF9.
  - -8*7 -> P=0xC8.
- Operand isolation: change A and B every cycle during RUN -> P reflects only the values captured at the START edge.
